// File: rtl/stream_egress_credit_pkg.sv
// rtl/stream_egress_credit_pkg.sv - shared defaults and width helper for the egress credit block
package stream_egress_credit_pkg;

    localparam int DATAW_DEFAULT = 32;
    localparam int LAT_DEFAULT   = 8;
    localparam int DEPTH_DEFAULT = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo_fwft.sv
// rtl/stream_fifo_fwft.sv - first-word-fall-through result buffer with occupancy count
module stream_fifo_fwft
    import stream_egress_credit_pkg::*;
#(
    parameter int DATAW = DATAW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] rdata,
    output logic [CW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    level_q, level_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level_q == DEPTH_W);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full buffer only lands when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + CW'(1);
            2'b01:   level_d = level_q - CW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/stream_egress_credit.sv
// rtl/stream_egress_credit.sv - egress controller tracking datapath tokens and buffering results with credit flow control
module stream_egress_credit
    import stream_egress_credit_pkg::*;
#(
    parameter int DATAW = DATAW_DEFAULT,
    parameter int LAT   = LAT_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ivalid,
    output logic             iready,
    output logic             dp_accept,
    input  logic [DATAW-1:0] dp_data,
    output logic             ovalid,
    input  logic             oready,
    output logic [DATAW-1:0] odata,
    output logic [CW-1:0]    level,
    output logic [CW-1:0]    inflight,
    output logic             overflow
);

    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

    logic [LAT-1:0] tok_q, tok_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic           overflow_q, overflow_d;
    logic [CW:0]    credit_sum;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    // Credit covers both buffered words and items still inside the datapath,
    // so every accepted item is guaranteed a buffer slot when it emerges.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, level};
    assign iready     = ~reset & (credit_sum < DEPTH_SUM);
    assign dp_accept  = ivalid & iready;
    assign push       = tok_q[LAT-1];
    assign ovalid     = ~empty;
    assign pop        = ovalid & oready;
    assign inflight   = inflight_q;
    assign overflow   = overflow_q;

    stream_fifo_fwft #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (dp_data),
        .rdata (odata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        tok_d      = tok_q;
        inflight_d = inflight_q;
        overflow_d = overflow_q;
        tok_d[0]   = dp_accept;
        for (int i = 1; i < LAT; i++) begin
            tok_d[i] = tok_q[i-1];
        end
        case ({dp_accept, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (push & full & ~pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tok_q      <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            assert (!(push && !dp_accept && inflight_q == '0))
                else $error("inflight counter underflow");
            tok_q      <= tok_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_stream_egress_credit.sv
// tb/tb_stream_egress_credit.sv - self-checking bench for stream_egress_credit
module tb_stream_egress_credit;
    import stream_egress_credit_pkg::*;

    localparam int DATAW = 32;
    localparam int LAT   = 8;
    localparam int DEPTH = 16;
    localparam int CW    = clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ivalid = 1'b0;
    logic             oready = 1'b0;
    logic             iready, dp_accept, ovalid, overflow;
    logic [DATAW-1:0] dp_data = '0;
    logic [DATAW-1:0] odata;
    logic [CW-1:0]    level, inflight;

    always #5 clock = ~clock;

    stream_egress_credit #(.DATAW(DATAW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .ivalid    (ivalid),
        .iready    (iready),
        .dp_accept (dp_accept),
        .dp_data   (dp_data),
        .ovalid    (ovalid),
        .oready    (oready),
        .odata     (odata),
        .level     (level),
        .inflight  (inflight),
        .overflow  (overflow)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_push  = 0;
    int          n_pop   = 0;
    int          seq     = 0;
    int          stamp_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] dl [LAT];
    logic [31:0] din = '0;
    logic        s_acc, s_pop, s_ov;
    int          s_cyc;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        acc;
        logic        ov;
        int          lvl;
        int          inf;
        logic        has_d;
        logic [31:0] d;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: an item is in flight for LAT edges after acceptance, then buffered until popped.
    task automatic check_model();
        int lvl, inf;
        lvl = n_push - n_pop;
        inf = stamp_q.size();
        chk("level", 32'(level), 32'(lvl));
        chk("inflight", 32'(inflight), 32'(inf));
        chk("iready", 32'(iready), 32'((inf + lvl) < DEPTH));
        chk("ovalid", 32'(ovalid), 32'(lvl != 0));
        chk("dp_accept", 32'(dp_accept), 32'(ivalid && ((inf + lvl) < DEPTH)));
        chk("overflow", 32'(overflow), 32'd0);
        chk("credit_bound", 32'((int'(inflight) + int'(level)) <= DEPTH), 32'd1);
        if (lvl != 0) begin
            chk("odata", odata, exp_q[0]);
        end
    endtask

    task automatic model_reset();
        stamp_q.delete();
        exp_q.delete();
        n_push = 0;
        n_pop  = 0;
        seq    = 0;
        din    = '0;
    endtask

    task automatic tick();
        @(negedge clock);
        check_model();
        s_acc = dp_accept;
        s_pop = ovalid & oready;
        s_ov  = ovalid;
        s_cyc = cyc;
        @(posedge clock);
        #1;
        cyc++;
        if (s_pop) begin
            n_pop++;
            void'(exp_q.pop_front());
        end
        if (s_acc) begin
            stamp_q.push_back(cyc);
            exp_q.push_back(din);
        end
        while (stamp_q.size() > 0 && stamp_q[0] <= cyc - LAT) begin
            void'(stamp_q.pop_front());
            n_push++;
        end
        for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0]   = s_acc ? din : (32'hBAD0_0000 | 32'(cyc));
        dp_data = dl[LAT-1];
        if (s_acc) seq++;
        din = 32'(seq);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ivalid = 1'b0;
        oready = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_iready", 32'(iready), 32'd0);
            chk("reset_ovalid", 32'(ovalid), 32'd0);
            chk("reset_level", 32'(level), 32'd0);
            chk("reset_inflight", 32'(inflight), 32'd0);
            @(posedge clock);
        end
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_first, ov_first, pops, last_pop, n, first_pop;

        for (int i = 0; i < LAT; i++) dl[i] = '0;

        // Hand-derived cycle table: two accepts, then a delayed two-word drain.
        vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 32'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0, 32'd0};
        for (int i = 2; i <= 8; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0, 32'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b1, 32'd0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 1'b1, 32'd0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 32'd1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'd0};

        do_reset();
        #1;
        chk("iready_after_reset", 32'(iready), 32'd1);
        for (int i = 0; i < 13; i++) begin
            ivalid = vt[i].iv;
            oready = vt[i].ordy;
            #1;
            chk("tbl_accept", 32'(dp_accept), 32'(vt[i].acc));
            chk("tbl_ovalid", 32'(ovalid), 32'(vt[i].ov));
            chk("tbl_level", 32'(level), 32'(vt[i].lvl));
            chk("tbl_inflight", 32'(inflight), 32'(vt[i].inf));
            if (vt[i].has_d) chk("tbl_odata", odata, vt[i].d);
            tick();
        end

        // Streaming: 64 items, no back-pressure.
        do_reset();
        oready = 1'b1;
        acc_first = -1; ov_first = -1; pops = 0; last_pop = -1;
        for (int k = 0; k < 300 && pops < 64; k++) begin
            ivalid = (seq < 64);
            tick();
            if (s_acc && acc_first < 0) acc_first = s_cyc;
            if (s_ov && ov_first < 0) ov_first = s_cyc;
            if (s_pop) begin
                pops++;
                last_pop = s_cyc;
            end
        end
        chk("stream_pops", 32'(pops), 32'd64);
        chk("stream_latency", 32'(ov_first - acc_first), 32'(LAT + 1));
        chk("stream_no_gaps", 32'(last_pop - ov_first + 1), 32'd64);

        // Back-pressure: oready held low.
        do_reset();
        ivalid = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (s_acc) n++;
        end
        chk("bp_accepts", 32'(n), 32'(DEPTH));
        chk("bp_iready", 32'(iready), 32'd0);
        chk("bp_level", 32'(level), 32'(DEPTH));
        chk("bp_inflight", 32'(inflight), 32'd0);
        chk("bp_overflow", 32'(overflow), 32'd0);
        oready = 1'b1;
        first_pop = -1;
        for (int k = 0; k < 10 && first_pop < 0; k++) begin
            tick();
            if (s_pop) first_pop = s_cyc;
        end
        chk("bp_iready_after_pop", 32'(iready), 32'd1);
        ivalid = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Random stalls on both sides.
        do_reset();
        for (int k = 0; k < 8000 && !(seq >= 256 && exp_q.size() == 0); k++) begin
            ivalid = (seq < 256) && ($urandom_range(0, 3) != 0);
            oready = ($urandom_range(0, 1) == 1);
            tick();
        end
        chk("rand_items", 32'(seq), 32'd256);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Wrap-around with oready toggled every 3 cycles.
        do_reset();
        for (int k = 0; k < 2000 && !(seq >= 40 && exp_q.size() == 0); k++) begin
            ivalid = (seq < 40);
            oready = ((k / 3) % 2 == 1);
            tick();
        end
        chk("wrap_items", 32'(seq), 32'd40);
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream with 5 buffered and 3 in flight.
        do_reset();
        oready = 1'b0;
        for (int k = 0; k < 13; k++) begin
            ivalid = (k < 5) || (k >= 10 && k < 13);
            tick();
        end
        ivalid = 1'b0;
        chk("mid_level", 32'(level), 32'd5);
        chk("mid_inflight", 32'(inflight), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_inflight", 32'(inflight), 32'd0);
        chk("async_ovalid", 32'(ovalid), 32'd0);
        chk("async_iready", 32'(iready), 32'd0);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        oready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        for (int k = 0; k < 200 && !(seq >= 5 && exp_q.size() == 0); k++) begin
            ivalid = (seq < 5);
            tick();
        end
        chk("post_reset_items", 32'(seq), 32'd5);
        chk("post_reset_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
